// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types for the matrix-keypad scanner.
package keypad_pkg;
  localparam int KP_MAX_KW = 6;
  typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} kp_state_t;
  // Frame result: the none flag marks "no key seen"; code is row*COLS+col.
  typedef struct packed {
    logic none;
    logic [KP_MAX_KW-1:0] code;
  } kp_result_t;
  localparam kp_result_t KP_NONE = '{none: 1'b1, code: '0};
  function automatic int key_width(input int rows, input int cols);
    return $clog2(rows * cols);
  endfunction
endpackage

// File: rtl/keypad_scan_timer.sv
// keypad_scan_timer: column dwell counter, active-low one-hot column drive,
// row sample strobe and end-of-frame tick.
module keypad_scan_timer #(
  parameter int COLS = 4,
  parameter int SCAN_DIV = 1024,
  localparam int CW = $clog2(COLS),
  localparam int DW = $clog2(SCAN_DIV)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [COLS-1:0] col_out,
  output logic [CW-1:0] col_idx,
  output logic          sample,
  output logic          frame_tick
);
  logic [DW-1:0] dwell;
  logic last_col;
  assign sample = dwell == DW'(SCAN_DIV - 1);
  assign last_col = col_idx == CW'(COLS - 1);
  assign col_out = ~(COLS'(1) << col_idx);
  // frame_tick lands on the first cycle of column 0, after the last column was sampled
  always_ff @(posedge clk)
    if (!rst_n) begin
      dwell <= '0;
      col_idx <= '0;
      frame_tick <= 1'b0;
    end else begin
      dwell <= sample ? '0 : dwell + DW'(1);
      if (sample) col_idx <= last_col ? '0 : col_idx + CW'(1);
      frame_tick <= sample && last_col;
    end
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: parametrised matrix-keypad scanner with frame debounce and key events.
// Optional auto-repeat of held keys when KEYPAD_AUTOREPEAT_EN is defined.
module keypad_scanner import keypad_pkg::*; #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int SCAN_DIV = 1024,
  parameter int DEBOUNCE_FRAMES = 3,
  parameter int REPEAT_DELAY_FRAMES = 32,
  parameter int REPEAT_RATE_FRAMES = 8,
  localparam int KW = key_width(ROWS, COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic            key_valid,
  output logic [KW-1:0]   key_code,
  output logic            key_held,
  output logic            key_multi
);
  localparam int CW = $clog2(COLS);
  logic [ROWS-1:0] row_s1, row_s2, hits;
  logic [CW-1:0] col_idx;
  logic sample, frame_tick;
  kp_result_t acc, first_hit, cand, cand_nxt;
  logic acc_multi, arm, hit, accept, rep_fire;
  kp_state_t state, state_nxt;
  logic [3:0] deb_cnt, deb_nxt, deb_inc;
  keypad_scan_timer #(.COLS(COLS), .SCAN_DIV(SCAN_DIV)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .col_out(col_out),
    .col_idx(col_idx),
    .sample(sample),
    .frame_tick(frame_tick)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      row_s1 <= '1;
      row_s2 <= '1;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
    end
  assign hits = ~row_s2;
  always_comb begin
    first_hit = KP_NONE;
    for (int r = ROWS - 1; r >= 0; r--)
      if (hits[r]) first_hit = '{none: 1'b0, code: KP_MAX_KW'(r * COLS) + KP_MAX_KW'(col_idx)};
  end
  // Columns are visited in order, so the first column with a hit wins
  always_ff @(posedge clk)
    if (!rst_n || frame_tick) begin
      acc <= KP_NONE;
      acc_multi <= 1'b0;
    end else if (sample) begin
      if (acc.none) acc <= first_hit;
      acc_multi <= acc_multi || $countones(hits) > 1 || (!acc.none && |hits);
    end
  assign hit = !acc.none && acc == cand;
  assign deb_inc = deb_cnt + 4'd1;
  always_ff @(posedge clk)
    if (!rst_n) begin
      state <= IDLE;
      deb_cnt <= '0;
      cand <= KP_NONE;
      arm <= 1'b1;
    end else begin
      state <= state_nxt;
      deb_cnt <= deb_nxt;
      cand <= cand_nxt;
      if (frame_tick) arm <= accept ? 1'b0 : (acc.none ? 1'b1 : arm);
    end
  // arm blocks a new press until an all-released frame follows the last accepted key
  always_comb begin
    state_nxt = state;
    deb_nxt = deb_cnt;
    cand_nxt = cand;
    accept = 1'b0;
    if (frame_tick)
      case (state)
        IDLE:
          if (!acc.none && arm) begin
            cand_nxt = acc;
            deb_nxt = 4'd1;
            accept = DEBOUNCE_FRAMES == 1;
            state_nxt = accept ? HELD : PRESS_PEND;
          end
        PRESS_PEND:
          if (hit) begin
            deb_nxt = deb_inc;
            accept = deb_inc >= 4'(DEBOUNCE_FRAMES);
            state_nxt = accept ? HELD : PRESS_PEND;
          end else begin
            cand_nxt = acc;
            deb_nxt = 4'd1;
            state_nxt = acc.none ? IDLE : PRESS_PEND;
          end
        HELD:
          if (!hit) begin
            deb_nxt = 4'd1;
            state_nxt = DEBOUNCE_FRAMES == 1 ? IDLE : REL_PEND;
          end
        REL_PEND:
          if (hit) state_nxt = HELD;
          else begin
            deb_nxt = deb_inc;
            state_nxt = deb_inc >= 4'(DEBOUNCE_FRAMES) ? IDLE : REL_PEND;
          end
        default: state_nxt = IDLE;
      endcase
  end
  always_comb key_held = state == HELD || state == REL_PEND;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RMAX = REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES ? REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int RW = $clog2(RMAX + 1);
  logic [RW-1:0] rep_cnt, rep_inc;
  logic rep_fast, rep_step;
  assign rep_step = frame_tick && state == HELD && hit;
  assign rep_inc = rep_cnt + RW'(1);
  assign rep_fire = rep_step && rep_inc == (rep_fast ? RW'(REPEAT_RATE_FRAMES) : RW'(REPEAT_DELAY_FRAMES));
  // Counter holds its value through REL_PEND so a brief bounce does not restart the delay
  always_ff @(posedge clk)
    if (!rst_n || state_nxt == IDLE) begin
      rep_cnt <= '0;
      rep_fast <= 1'b0;
    end else if (rep_fire) begin
      rep_cnt <= '0;
      rep_fast <= 1'b1;
    end else if (rep_step) rep_cnt <= rep_inc;
`else
  assign rep_fire = 1'b0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) begin
      key_valid <= 1'b0;
      key_code <= '0;
      key_multi <= 1'b0;
    end else begin
      key_valid <= accept || rep_fire;
      if (accept) key_code <= cand_nxt.code[KW-1:0];
      if (frame_tick) key_multi <= acc_multi;
    end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scan order, debounce, multi-key and reset behaviour.
// Auto-repeat expectations switch on with KEYPAD_AUTOREPEAT_EN.
module tb_keypad_scanner;
`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int AR = 1;
`else
  localparam int AR = 0;
`endif
  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] row_in, col_out, key_code;
  logic key_valid, key_held, key_multi;
  logic [15:0] keys;
  int checks = 0;
  int failures = 0;
  int vcount = 0;
  keypad_scanner #(
    .ROWS(4), .COLS(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(3),
    .REPEAT_DELAY_FRAMES(4), .REPEAT_RATE_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .row_in(row_in),
    .col_out(col_out),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_held(key_held),
    .key_multi(key_multi)
  );
  always #5 clk = ~clk;
  always_comb begin
    row_in = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_out[c] && keys[r*4+c]) row_in[r] = 1'b0;
  end
  always @(negedge clk) if (rst_n && key_valid) vcount++;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic next_frame();
    int n = 0;
    while (col_out != 4'b0111 && n < 64) begin @(negedge clk); n++; end
    while (col_out != 4'b1110 && n < 64) begin @(negedge clk); n++; end
    if (n >= 64) check("frame_timeout", n, 0);
  endtask
  task automatic frames(input int n);
    repeat (n) next_frame();
    repeat (3) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0;
    keys = '0;
    repeat (3) @(negedge clk);
    check("rst_col", col_out, 4'b1110);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_held", key_held, 0);
    check("rst_multi", key_multi, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("col_step1", col_out, 4'b1101);
    repeat (4) @(negedge clk);
    check("col_step2", col_out, 4'b1011);
    repeat (4) @(negedge clk);
    check("col_step3", col_out, 4'b0111);
    repeat (4) @(negedge clk);
    check("col_wrap", col_out, 4'b1110);
    keys = 16'd1 << 9;
    frames(6);
    check("press_count", vcount, 1);
    check("press_code", key_code, 9);
    check("press_held", key_held, 1);
    check("press_multi", key_multi, 0);
    keys = '0;
    frames(2);
    check("rel_held_2", key_held, 1);
    frames(1);
    check("rel_held_3", key_held, 0);
    check("rel_count", vcount, 1);
    repeat (4) begin
      keys = 16'd1 << 9;
      frames(1);
      keys = '0;
      frames(1);
    end
    check("bounce_count", vcount, 1);
    check("bounce_held", key_held, 0);
    keys = (16'd1 << 1) | (16'd1 << 6);
    frames(4);
    check("two_count", vcount, 2);
    check("two_code", key_code, 1);
    check("two_multi", key_multi, 1);
    check("two_held", key_held, 1);
    keys = 16'd1 << 6;
    frames(8);
    check("drop_count", vcount, 2);
    check("drop_held", key_held, 0);
    check("drop_multi", key_multi, 0);
    keys = '0;
    frames(2);
    keys = 16'd1 << 6;
    frames(4);
    check("repress_count", vcount, 3);
    check("repress_code", key_code, 6);
    keys = '0;
    frames(4);
    keys = 16'd1 << 9;
    frames(2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_code", key_code, 0);
    check("midrst_held", key_held, 0);
    check("midrst_col", col_out, 4'b1110);
    frames(2);
    check("midrst_pending", vcount, 3);
    frames(1);
    check("midrst_accept", vcount, 4);
    check("midrst_code9", key_code, 9);
    keys = '0;
    frames(4);
    keys = 16'd1 << 15;
    frames(3);
    check("k15_accept", vcount, 5);
    check("k15_code", key_code, 15);
    frames(3);
    check("k15_before_rep", vcount, 5);
    frames(1);
    check("k15_first_rep", vcount, 5 + AR);
    frames(8);
    check("k15_reps", vcount, 5 + 5 * AR);
    check("k15_rep_code", key_code, 15);
    keys = '0;
    frames(6);
    check("k15_after_rel", vcount, 5 + 5 * AR);
    check("k15_held", key_held, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Parametrised matrix-keypad scanner; generalises the fixed 4x4 row/column keypad path feeding the calculator.
- Drives one column at a time and samples synchronised row inputs.
- Debounces over whole scan frames and emits a one-cycle key event with a linear key code, plus a held flag.
- Sits between the top-level pins (row in, column out) and the application logic (calculator, display controller).

Parameters:
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column outputs (2..8)
- SCAN_DIV, 1024, clk cycles per column dwell; must be >= 4
- DEBOUNCE_FRAMES, 3, consecutive identical frames needed to accept a press or a release (1..15)
- REPEAT_DELAY_FRAMES, 32, frames of hold before the first repeat (auto-repeat build only)
- REPEAT_RATE_FRAMES, 8, frames between subsequent repeats (auto-repeat build only)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- row_in  in  ROWS  raw row lines; pulled up externally, low = key pressed in the driven column
- col_out  out  COLS  column drive, active-low one-hot
- key_valid  out  1  one-cycle pulse; new key event
- key_code  out  KW  row*COLS+col, KW = clog2(ROWS*COLS); stable until the next event
- key_held  out  1  high while the accepted key remains debounced-pressed
- key_multi  out  1  high for the frame result when more than one key was seen in the last frame

Behaviour:
- Reset (rst_n=0 at a clk edge): col_out = all ones except bit0 = 0; key_valid=0; key_code=0; key_held=0; key_multi=0; all counters and the FSM clear; FSM goes to IDLE. Reset mid-scan or mid-debounce discards all partial state.
- row_in passes through a 2-flop synchroniser.
- Dwell counter counts 0..SCAN_DIV-1. Rows are sampled when the counter reaches SCAN_DIV-1; the column advances on the next cycle.
- The column index wraps from COLS-1 to 0. The wrap cycle ends a frame (frame_tick, internal).
- Frame result: first pressed key in column-major order (lowest col, then lowest row), else NONE. key_multi = 1 if at least two keys were pressed in the frame; it updates at frame_tick.
- FSM advances only on frame_tick, with deb_cnt as the frame counter:
  - IDLE: result != NONE -> PRESS_PEND; latch candidate; deb_cnt = 1.
  - PRESS_PEND, result == candidate: deb_cnt++.
    - When deb_cnt reaches DEBOUNCE_FRAMES: go to HELD, pulse key_valid, load key_code, set key_held.
    - With DEBOUNCE_FRAMES=1, acceptance happens on the first frame.
  - PRESS_PEND, result != candidate: if result == NONE go to IDLE, otherwise restart with the new candidate.
  - HELD, result == candidate: stay.
  - HELD, otherwise (NONE or a different key): go to REL_PEND; deb_cnt = 1.
  - REL_PEND: DEBOUNCE_FRAMES consecutive frames without the candidate -> IDLE; key_held=0.
    - Candidate reappears -> back to HELD, with no new event.
  - A different key is never reported until the old key is released, i.e. the FSM passes through IDLE.
- key_valid is asserted exactly one cycle, the cycle after frame_tick. Worst-case press latency is (DEBOUNCE_FRAMES+1)*COLS*SCAN_DIV + 3 cycles.

Optional Feature:
- Macro: KEYPAD_AUTOREPEAT_EN.
- Defined:
  - In HELD, a repeat counter counts frames.
  - After REPEAT_DELAY_FRAMES, key_valid pulses again with the same key_code.
  - Further repeats follow every REPEAT_RATE_FRAMES.
  - The counter clears on leaving HELD and is frozen during REL_PEND.
- Undefined: no repeat counter exists; exactly one key_valid per press.

Decomposition:
- Package keypad_pkg holds:
  - FSM state enum: IDLE, PRESS_PEND, HELD, REL_PEND
  - key code width function
  - NONE encoding, an internal flag bit alongside the code
- One sub-module, keypad_scan_timer: dwell counter, column index, col_out one-hot generation, sample strobe and frame_tick.
- The FSM, frame reduction and repeat logic stay in keypad_scanner.

Test Plan (ROWS=4, COLS=4, SCAN_DIV=4, DEBOUNCE_FRAMES=3; frame = 16 cycles):
- Reset: hold rst_n=0 for 3 cycles -> col_out=4'b1110, key_valid=0, key_code=0, key_held=0. Release -> col_out steps 1101, 1011, 0111, 1110 every 4 cycles.
- Clean press: row2 driven low whenever col1 is active, held for 6 frames -> exactly one key_valid, key_code=9, key_held=1. Release -> key_held=0 after 3 NONE frames.
- Bounce: key 9 present in alternate frames for 8 frames -> no key_valid; FSM oscillates between PRESS_PEND and IDLE.
- Two keys: keys 1 and 6 held together -> key_code=1 accepted, key_multi=1. Drop key 1 while key 6 stays held -> no new event until both are released and key 6 is pressed again.
- Reset mid-debounce: rst_n pulsed low during PRESS_PEND frame 2 -> no key_valid; full 3-frame debounce restarts after reset.
- KEYPAD_AUTOREPEAT_EN with REPEAT_DELAY_FRAMES=4, REPEAT_RATE_FRAMES=2, key 15 held for 12 frames after acceptance -> repeats at frames 4, 6, 8, 10, 12, all with key_code=15; no repeats after release.
